mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter_starve_counter.sv | 34 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared state/owner encodings and arbitration defaults.
// Rev    : 1.0
// ============================================================================
package mem_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t c_ST_IDLE = 2'd0;
    localparam arb_state_t c_ST_CORE = 2'd1;
    localparam arb_state_t c_ST_DBG  = 2'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam int c_DEF_STARVE_LIMIT = 8;
    localparam int c_DEF_MAX_BURST    = 4;

    function automatic owner_t f_state_owner(input arb_state_t st);
        case (st)
            c_ST_CORE: return OWN_CORE;
            c_ST_DBG:  return OWN_DBG;
            default:   return OWN_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module : arb_starve_counter
// Brief  : Saturating 4-bit count of cycles the loader has waited ungranted.
// Rev    : 1.0
// ============================================================================
module arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_granted,
    output logic o_starved
);

    localparam logic [3:0] c_LIMIT = 4'(LIMIT);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (!i_req || i_granted) begin
            r_cnt <= 4'd0;
        end else if (r_cnt != c_LIMIT) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_starved = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Two-port (core / debug loader) arbiter onto a single memory port.
// Rev    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = c_DEF_STARVE_LIMIT,
    parameter int MAX_BURST    = c_DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [DATA_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_core_stall,

    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic              i_dbg_lock,
    input  logic [DATA_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,

    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

    arb_state_t        r_state;
    logic              r_core_gnt;
    logic              r_dbg_gnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_burst_cnt;
    logic              r_core_rvalid;
    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    logic              w_starved;
    logic              w_burst_active;
    logic              w_dbg_win;
    logic              w_core_win;
    logic [3:0]        w_burst_inc;
    owner_t            w_rd_owner;

    // A burst only keeps the loader in front while it is still asking with lock high.
    assign w_burst_active = (r_burst_cnt != 4'd0) && i_dbg_req && i_dbg_lock;
    assign w_dbg_win      = i_dbg_req && (!i_core_req || w_starved || w_burst_active);
    assign w_core_win     = i_core_req && !w_dbg_win;
    assign w_burst_inc    = r_burst_cnt + 4'd1;
    assign w_rd_owner     = r_mem_we ? OWN_NONE : f_state_owner(r_state);

    arb_starve_counter #(
        .LIMIT     (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_dbg_req),
        .i_granted (w_dbg_win),
        .o_starved (w_starved)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_core_gnt  <= 1'b0;
            r_dbg_gnt   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_core_win) begin
            r_state     <= c_ST_CORE;
            r_core_gnt  <= 1'b1;
            r_dbg_gnt   <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_core_we;
            r_mem_addr  <= i_core_addr;
            r_mem_wdata <= i_core_wdata;
        end else if (w_dbg_win) begin
            r_state     <= c_ST_DBG;
            r_core_gnt  <= 1'b0;
            r_dbg_gnt   <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_dbg_we;
            r_mem_addr  <= i_dbg_addr;
            r_mem_wdata <= i_dbg_wdata;
        end else begin
            r_state     <= c_ST_IDLE;
            r_core_gnt  <= 1'b0;
            r_dbg_gnt   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    // Reaching MAX_BURST closes the burst so the core gets the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 4'd0;
        end else if (w_dbg_win && i_dbg_lock) begin
            r_burst_cnt <= (w_burst_inc == c_MAX_BURST) ? 4'd0 : w_burst_inc;
        end else begin
            r_burst_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rvalid <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
            r_core_rdata  <= '0;
            r_dbg_rdata   <= '0;
        end else begin
            r_core_rvalid <= (w_rd_owner == OWN_CORE);
            r_dbg_rvalid  <= (w_rd_owner == OWN_DBG);
            if (r_core_rvalid) begin
                r_core_rdata <= i_mem_rdata;
            end
            if (r_dbg_rvalid) begin
                r_dbg_rdata <= i_mem_rdata;
            end
        end
    end

    // Read data arrives from memory in the rvalid cycle; the registers keep it afterwards.
    assign o_core_rdata  = r_core_rvalid ? i_mem_rdata : r_core_rdata;
    assign o_dbg_rdata   = r_dbg_rvalid  ? i_mem_rdata : r_dbg_rdata;
    assign o_core_rvalid = r_core_rvalid;
    assign o_dbg_rvalid  = r_dbg_rvalid;
    assign o_core_gnt    = r_core_gnt;
    assign o_dbg_gnt     = r_dbg_gnt;
    assign o_core_stall  = i_core_req && !r_core_gnt;
    assign o_mem_en      = r_mem_en;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire
